// File: rtl/approx_div_pkg.sv
// Shared definitions for the approximate unsigned divider family.
//   state_t      : sequencer states (IDLE, BUSY, DONE)
//   DVD_W/DVS_W  : dividend / divisor widths
//   CNT_W        : iteration counter width (one step per dividend bit)
//   DBZ_QUOT_DEF : default quotient reported on divide-by-zero
//   dvd_mask()   : mask that clears the low l dividend bits
package approx_div_pkg;

  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  localparam int CNT_W = 4;
  localparam int REM_W = DVS_W + 1;

  localparam logic [DVD_W-1:0] DBZ_QUOT_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // All-ones with the low l bits cleared. l = 0 leaves the dividend exact.
  function automatic logic [DVD_W-1:0] dvd_mask(input int l);
    logic [DVD_W-1:0] m;
    m = '1;
    m = m << l;
    return m;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring division step (purely combinational).
//   rem_in  : current partial remainder (9 bits, top bit is always 0 here)
//   dvd_bit : next dividend bit, shifted in at the bottom
//   divisor : 8-bit divisor
//   rem_out : partial remainder after the trial subtraction
//   q_bit   : quotient bit produced by this step
module restoring_div_step
  import approx_div_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [REM_W-1:0] rem_out,
  output logic             q_bit
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] diff;

  // After a restoring step the remainder is always < divisor, so its MSB
  // carries no information; only the low 8 bits are shifted up.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_in[REM_W-1];

  assign shifted = {rem_in[DVS_W-1:0], dvd_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/approx_unsigned_divider_16by8_seq.sv
// Sequential 16/8 unsigned divider, radix-2 restoring, one quotient bit per
// clock. Optionally truncates the low APPROX_L dividend bits first so it
// mirrors the truncation level of the approximate multiplier family.
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid/in_ready, dividend, divisor   : operand handshake
//   out_valid/out_ready, quotient, remainder, div_by_zero : result handshake
// Normal ops finish 16 edges after acceptance; divide-by-zero goes straight
// to DONE on the acceptance edge.
module approx_unsigned_divider_16by8_seq
  import approx_div_pkg::*;
#(
  parameter int               APPROX_L = 0,
  parameter logic [DVD_W-1:0] DBZ_QUOT = DBZ_QUOT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [DVD_W-1:0] MASK = dvd_mask(APPROX_L);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd_sh;   // dividend, consumed MSB-first
  logic [DVS_W-1:0] dvs_q;
  logic [REM_W-1:0] rem_q;
  logic [DVD_W-1:0] quo_sh;

  logic [DVD_W-1:0] dvd_eff;
  logic [REM_W-1:0] step_rem;
  logic             step_q;
  logic [DVD_W-1:0] quo_next;

  assign dvd_eff  = dividend & MASK;
  assign quo_next = {quo_sh[DVD_W-2:0], step_q};

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  restoring_div_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_sh[DVD_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_sh      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dvd_sh <= dvd_eff;
            dvs_q  <= divisor;
            rem_q  <= '0;
            quo_sh <= '0;
            if (divisor == '0) begin
              quotient    <= DBZ_QUOT;
              remainder   <= dvd_eff[DVS_W-1:0];
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cnt   <= CNT_W'(DVD_W - 1);
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          rem_q  <= step_rem;
          dvd_sh <= {dvd_sh[DVD_W-2:0], 1'b0};
          quo_sh <= quo_next;
          cnt    <= cnt - 1'b1;
          // Result registers only load on the final step, so a partial
          // quotient never reaches the outputs.
          if (cnt == '0) begin
            quotient    <= quo_next;
            remainder   <= step_rem[DVS_W-1:0];
            div_by_zero <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_unsigned_divider_16by8_seq.sv
module tb_approx_unsigned_divider_16by8_seq;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[2], ir[2], ov[2], ordy[2], dz[2];
  logic [15:0] dvd[2], quo[2];
  logic [7:0]  dvs[2], rem[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_unsigned_divider_16by8_seq #(.APPROX_L(0)) u_exact (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .dividend(dvd[0]), .divisor(dvs[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .quotient(quo[0]),
    .remainder(rem[0]), .div_by_zero(dz[0])
  );

  approx_unsigned_divider_16by8_seq #(.APPROX_L(2)) u_apx2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .dividend(dvd[1]), .divisor(dvs[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .quotient(quo[1]),
    .remainder(rem[1]), .div_by_zero(dz[1])
  );

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // Reference: truncate the low l bits, then plain integer division.
  task automatic model(input int l, input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
    int d;
    d = (int'(a) >> l) << l;
    if (b == 0) begin
      q = 16'hFFFF; r = d[7:0]; z = 1'b1;
    end else begin
      q = 16'(d / int'(b)); r = 8'(d % int'(b)); z = 1'b0;
    end
  endtask

  // Present operands, wait for acceptance, then wait for out_valid without
  // consuming. lat = rising edges after the acceptance edge until out_valid.
  // With noise set, in_valid stays high with junk operands while busy.
  task automatic run_op(input int s, input logic [15:0] a, input logic [7:0] b,
                        input bit noise, output int lat,
                        output logic [15:0] q, output logic [7:0] r, output logic z);
    int w;
    @(negedge clk);
    iv[s] = 1'b1; dvd[s] = a; dvs[s] = b;
    w = 0;
    while (!ir[s] && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("accept_timeout", w, 0);
    @(negedge clk);
    if (noise) begin dvd[s] = 16'd9; dvs[s] = 8'd2; end
    else iv[s] = 1'b0;
    lat = 0;
    while (!ov[s] && lat < 100) begin
      if (noise) chk("busy_in_ready", ir[s], 0);
      @(negedge clk);
      lat++;
    end
    iv[s] = 1'b0;
    if (lat >= 100) chk("done_timeout", lat, 0);
    q = quo[s]; r = rem[s]; z = dz[s];
    chk("done_in_ready", ir[s], 0);
  endtask

  task automatic consume(input int s);
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    chk("post_hs_out_valid", ov[s], 0);
    chk("post_hs_in_ready", ir[s], 1);
  endtask

  task automatic chk_reset_vals(input int s);
    chk("rst_in_ready", ir[s], 1);
    chk("rst_out_valid", ov[s], 0);
    chk("rst_quotient", quo[s], 0);
    chk("rst_remainder", rem[s], 0);
    chk("rst_dbz", dz[s], 0);
  endtask

  initial begin
    vec_t        vecs[6];
    int          lat;
    logic [15:0] q, eq, q0;
    logic [7:0]  r, er, r0;
    logic        z, ez, seen;
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6, 1'b0};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0, 1'b0};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0};
    vecs[3] = '{16'd0,     8'd9,   16'd0,     8'd0, 1'b0};
    vecs[4] = '{16'd6,     8'd200, 16'd0,     8'd6, 1'b0};
    vecs[5] = '{16'd5,     8'd0,   16'hFFFF,  8'd5, 1'b1};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; dvd[s] = '0; dvs[s] = '0;
    end
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst = 1'b0;
    @(negedge clk);

    // Directed table on the exact instance, including latency.
    for (int i = 0; i < 6; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, 1'b0, lat, q, r, z);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), z, vecs[i].z);
      // Normal: out_valid after 16 edges; divide-by-zero: already high in
      // the cycle following the acceptance edge.
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 0 : 16);
      consume(0);
    end

    // Truncated dividend: 1003 seen as 1000.
    run_op(1, 16'd1003, 8'd7, 1'b0, lat, q, r, z);
    chk("apx_quot", q, 142);
    chk("apx_rem", r, 6);
    chk("apx_dbz", z, 0);
    consume(1);

    // Backpressure: hold the result for 10 cycles.
    run_op(0, 16'd50000, 8'd123, 1'b0, lat, q0, r0, z);
    chk("bp_quot", q0, 406);
    chk("bp_rem", r0, 62);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", ov[0], 1);
      chk("bp_in_ready", ir[0], 0);
      chk("bp_quot_stable", quo[0], q0);
      chk("bp_rem_stable", rem[0], r0);
    end
    consume(0);

    // in_valid held with other operands while busy must be ignored.
    run_op(0, 16'd1000, 8'd7, 1'b1, lat, q, r, z);
    chk("noise_quot", q, 142);
    chk("noise_rem", r, 6);
    chk("noise_latency", lat, 16);
    consume(0);

    // Random sweeps against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 8'($urandom_range(0, 255));
      run_op(0, ra, rb, 1'b0, lat, q, r, z);
      model(0, ra, rb, eq, er, ez);
      chk("rnd0_quot", q, eq); chk("rnd0_rem", r, er); chk("rnd0_dbz", z, ez);
      consume(0);
    end
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom); rb = 8'($urandom_range(0, 255));
      run_op(1, ra, rb, 1'b0, lat, q, r, z);
      model(2, ra, rb, eq, er, ez);
      chk("rnd2_quot", q, eq); chk("rnd2_rem", r, er); chk("rnd2_dbz", z, ez);
      consume(1);
    end

    // Reset 8 cycles into BUSY aborts with no result.
    @(negedge clk);
    iv[0] = 1'b1; dvd[0] = 16'd1000; dvs[0] = 8'd7;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("abort_busy", ir[0], 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(0, 16'd200, 8'd3, 1'b0, lat, q, r, z);
    chk("post_abort_quot", q, 66);
    chk("post_abort_rem", r, 2);
    chk("post_abort_dbz", z, 0);
    consume(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
